// File: rtl/ctrl_pkg.sv
// Shared constants for the bus-computer control sequencer: opcodes,
// control-word bit positions, step limits and per-opcode instruction lengths.
package ctrl_pkg;

    // Opcodes as seen on IR[7:4]
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_STA = 4'd4;
    localparam logic [3:0] OP_LDI = 4'd5;
    localparam logic [3:0] OP_JMP = 4'd6;
    localparam logic [3:0] OP_JC  = 4'd7;
    localparam logic [3:0] OP_JZ  = 4'd8;
    localparam logic [3:0] OP_OUT = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    // Control-word bit indices
    localparam int unsigned CB_HLT = 15;
    localparam int unsigned CB_MI  = 14;
    localparam int unsigned CB_RI  = 13;
    localparam int unsigned CB_RO  = 12;
    localparam int unsigned CB_IO  = 11;
    localparam int unsigned CB_II  = 10;
    localparam int unsigned CB_AI  = 9;
    localparam int unsigned CB_AO  = 8;
    localparam int unsigned CB_EO  = 7;
    localparam int unsigned CB_SU  = 6;
    localparam int unsigned CB_BI  = 5;
    localparam int unsigned CB_OI  = 4;
    localparam int unsigned CB_CE  = 3;
    localparam int unsigned CB_CO  = 2;
    localparam int unsigned CB_J   = 1;
    localparam int unsigned CB_FI  = 0;

    localparam logic [2:0] MAX_STEP = 3'd4;
    localparam logic [2:0] HLT_STEP = 3'd2;

    // Instruction lengths in clocks when trailing empty steps are skipped
    localparam logic [2:0] LEN_NOP      = 3'd2;
    localparam logic [2:0] LEN_LDA      = 3'd4;
    localparam logic [2:0] LEN_ADD      = 3'd5;
    localparam logic [2:0] LEN_SUB      = 3'd5;
    localparam logic [2:0] LEN_STA      = 3'd4;
    localparam logic [2:0] LEN_LDI      = 3'd3;
    localparam logic [2:0] LEN_JMP      = 3'd3;
    localparam logic [2:0] LEN_JX_TAKEN = 3'd3;
    localparam logic [2:0] LEN_JX_NOT   = 3'd2;
    localparam logic [2:0] LEN_OUT      = 3'd3;
    localparam logic [2:0] LEN_HLT      = 3'd3;

    // One-hot mask for a single control bit
    function automatic logic [15:0] cbit(input int unsigned idx);
        return 16'd1 << idx;
    endfunction

endpackage

// File: rtl/ctrl_microcode.sv
// Combinational microcode ROM: (opcode, step, flags) -> control word and
// a flag marking the final non-empty step of the current instruction.
module ctrl_microcode
    import ctrl_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [2:0]  step,
    input  logic        flag_c,
    input  logic        flag_z,
    output logic [15:0] ctrl,
    output logic        last
);

    logic [15:0] t2;
    logic [15:0] t3;
    logic [15:0] t4;
    logic [2:0]  len;

    // Execute-phase words and instruction length for the current opcode
    always_comb begin
        t2  = 16'h0000;
        t3  = 16'h0000;
        t4  = 16'h0000;
        len = LEN_NOP;
        case (opcode)
            OP_LDA: begin
                t2  = cbit(CB_IO) | cbit(CB_MI);
                t3  = cbit(CB_RO) | cbit(CB_AI);
                len = LEN_LDA;
            end
            OP_ADD: begin
                t2  = cbit(CB_IO) | cbit(CB_MI);
                t3  = cbit(CB_RO) | cbit(CB_BI);
                t4  = cbit(CB_EO) | cbit(CB_AI) | cbit(CB_FI);
                len = LEN_ADD;
            end
            OP_SUB: begin
                t2  = cbit(CB_IO) | cbit(CB_MI);
                t3  = cbit(CB_RO) | cbit(CB_BI);
                t4  = cbit(CB_EO) | cbit(CB_SU) | cbit(CB_AI) | cbit(CB_FI);
                len = LEN_SUB;
            end
            OP_STA: begin
                t2  = cbit(CB_IO) | cbit(CB_MI);
                t3  = cbit(CB_AO) | cbit(CB_RI);
                len = LEN_STA;
            end
            OP_LDI: begin
                t2  = cbit(CB_IO) | cbit(CB_AI);
                len = LEN_LDI;
            end
            OP_JMP: begin
                t2  = cbit(CB_IO) | cbit(CB_J);
                len = LEN_JMP;
            end
            OP_JC: begin
                t2  = flag_c ? (cbit(CB_IO) | cbit(CB_J)) : 16'h0000;
                len = flag_c ? LEN_JX_TAKEN : LEN_JX_NOT;
            end
            OP_JZ: begin
                t2  = flag_z ? (cbit(CB_IO) | cbit(CB_J)) : 16'h0000;
                len = flag_z ? LEN_JX_TAKEN : LEN_JX_NOT;
            end
            OP_OUT: begin
                t2  = cbit(CB_AO) | cbit(CB_OI);
                len = LEN_OUT;
            end
            OP_HLT: begin
                t2  = cbit(CB_HLT);
                len = LEN_HLT;
            end
            default: ;  // NOP and undefined opcodes: no execute strobes
        endcase
    end

    // Select the word for the current step; fetch is common to all opcodes
    always_comb begin
        ctrl = 16'h0000;
        case (step)
            3'd0:    ctrl = cbit(CB_CO) | cbit(CB_MI);
            3'd1:    ctrl = cbit(CB_RO) | cbit(CB_II) | cbit(CB_CE);
            3'd2:    ctrl = t2;
            3'd3:    ctrl = t3;
            3'd4:    ctrl = t4;
            default: ctrl = 16'h0000;
        endcase
        last = (step == (len - 3'd1));
    end

endmodule

// File: rtl/eater_ctrl.sv
// Control sequencer top: step counter, HLT freeze and instruction wrap.
// Build option: define CTRL_EARLY_END_EN to wrap each instruction after its
// last non-empty step instead of always running steps 0..4.
module eater_ctrl
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  opcode,
    input  logic        flag_c,
    input  logic        flag_z,
    output logic [15:0] ctrl,
    output logic [2:0]  step,
    output logic        halted
);

    logic [2:0] step_q;
    logic [2:0] step_d;
    logic       last;
    logic       wrap;

    ctrl_microcode u_microcode (
        .opcode (opcode),
        .step   (step_q),
        .flag_c (flag_c),
        .flag_z (flag_z),
        .ctrl   (ctrl),
        .last   (last)
    );

    // IR is not reloaded while halted, so the opcode stays HLT until clr
    assign halted = (step_q == HLT_STEP) && (opcode == OP_HLT);
    assign step   = step_q;

`ifdef CTRL_EARLY_END_EN
    assign wrap = last;
`else
    logic unused_last;
    assign unused_last = last;
    assign wrap        = (step_q == MAX_STEP);
`endif

    // Next step: hold on HLT, wrap at instruction end, else advance
    always_comb begin
        step_d = step_q + 3'd1;
        if (halted) begin
            step_d = step_q;
        end else if (wrap) begin
            step_d = 3'd0;
        end
    end

    // Step counter with asynchronous clear
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            step_q <= 3'd0;
        end else begin
            step_q <= step_d;
        end
    end

endmodule
